// File: rtl/mux_4to1_rr.sv
// Round-robin 4-to-1 valid/ready merge with one registered output stage and source tag on sel.
// Optional per-channel accepted-transfer counters are built when MUX_CNT_EN is defined.
module mux_4to1_rr #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             v0,
  input  logic             v1,
  input  logic             v2,
  input  logic             v3,
  output logic             r0,
  output logic             r1,
  output logic             r2,
  output logic             r3,
  output logic [WIDTH-1:0] o,
  output logic [1:0]       sel,
  output logic             o_valid,
  input  logic             o_ready
`ifdef MUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("mux_4to1_rr: WIDTH and CNT_W must be at least 1");
  end

  logic [WIDTH-1:0] data_s [4];
  logic [3:0]       v_s;
  logic [3:0]       ready_s;
  logic             load_en_s;
  logic             any_s;
  logic [1:0]       gnt_s;
  logic [2:0]       pick_s;

  logic [WIDTH-1:0] o_q, o_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic             valid_q, valid_d;

  // Returns {found, index} of the first requester after 'last' in circular order.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!res[2] && req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign data_s[0] = i0;
  assign data_s[1] = i1;
  assign data_s[2] = i2;
  assign data_s[3] = i3;
  assign v_s       = {v3, v2, v1, v0};

  // Arbitration, per-channel ready and next-state of the output stage.
  always_comb begin
    load_en_s = !valid_q || o_ready;
    pick_s    = rr_pick(v_s, last_q);
    any_s     = pick_s[2];
    gnt_s     = pick_s[1:0];
    ready_s   = 4'b0000;
    o_d       = o_q;
    sel_d     = sel_q;
    last_d    = last_q;
    valid_d   = valid_q;
    // Ready is forced low during reset so no source sees a phantom transfer.
    if (rst_n && load_en_s && any_s) begin
      ready_s[gnt_s] = 1'b1;
    end else begin
      ready_s = 4'b0000;
    end
    if (load_en_s) begin
      if (any_s) begin
        o_d     = data_s[gnt_s];
        sel_d   = gnt_s;
        last_d  = gnt_s;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register stage and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q     <= '0;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      valid_q <= 1'b0;
    end else begin
      o_q     <= o_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign r0      = ready_s[0];
  assign r1      = ready_s[1];
  assign r2      = ready_s[2];
  assign r3      = ready_s[3];
  assign o       = o_q;
  assign sel     = sel_q;
  assign o_valid = valid_q;

`ifdef MUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];

  // Per-channel accepted-transfer counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (v_s[k] && ready_s[k]) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end else begin
          cnt_q[k] <= cnt_q[k];
        end
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule

// File: doc/mux_4to1_rr.md
Name: mux_4to1_rr

Overview:
4-to-1 data-routing multiplexer. It merges four independent valid/ready input channels onto one registered output channel and tags each word with the index of its source channel on sel. It is the merge-side counterpart of the 1-to-4 demux, so a downstream demux can route each word back by sel. Arbitration is round-robin, with one output register stage.

Parameters:
WIDTH, 1, data width of each channel and of the output
CNT_W, 8, width of the per-channel transfer counters (used only with MUX_CNT_EN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
i0..i3  input  WIDTH  channel 0..3 data
v0..v3  input  1  channel 0..3 valid
r0..r3  output  1  channel 0..3 ready; a transfer occurs when vk & rk at a clk edge
o  output  WIDTH  registered output data
sel  output  2  registered source-channel index of o
o_valid  output  1  o/sel hold a word
o_ready  input  1  downstream accepts the word; transfer when o_valid & o_ready
cnt0..cnt3  output  CNT_W  per-channel accepted-transfer count (MUX_CNT_EN only)

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed):
  - o=0, sel=0, o_valid=0.
  - Round-robin pointer last=3, so channel 0 has first priority.
  - r0..r3=0 while rst_n=0.
- Two implicit states held in o_valid:
  - EMPTY (o_valid=0).
  - FULL (o_valid=1).
- load_en = !o_valid | o_ready.
- Grant: the first channel with vk=1 in order last+1, last+2, last+3, last+4 (mod 4).
- rk = load_en & (grant==k) & (any vk). rk may depend combinationally on v0..v3 and o_ready.
  - At most one rk is high per cycle.
  - rk is never high for a channel whose vk=0.
- At a clk edge with load_en=1:
  - A grant exists: o<=i[grant], sel<=grant, o_valid<=1, last<=grant.
  - No channel valid: o_valid<=0; o, sel and last hold.
- At a clk edge with load_en=0 (FULL, o_ready=0): o, sel, o_valid and last hold, and all rk=0.
- Latency is 1 cycle from an input transfer to o_valid.
- Throughput is one word per cycle while o_ready=1.
- Fairness: with all four channels continuously valid, grants rotate 0,1,2,3,0,... Each channel is served once every 4 transfers.
- Input rule: a source holds ik stable and vk high until rk. The block does not check this rule.
- Output rule: o and sel stay stable while o_valid=1 and o_ready=0.
- Simultaneous events:
  - Output consumed and new word loaded in the same cycle: no bubble.
  - A channel raises vk in the same cycle another is granted: that channel waits for the next rotation.
- Reset mid-operation: a word in flight is discarded, and arbitration restarts at channel 0.

Optional Feature:
- Macro: MUX_CNT_EN.
- Defined:
  - Ports cnt0..cnt3 exist, reset to 0.
  - cntk increments by 1 on each accepted input transfer (vk & rk).
  - Counts wrap from 2^CNT_W-1 to 0.
- Undefined: the counter ports and their logic are absent. Mux behaviour is identical in both cases.

Test Plan:
- Reset, with WIDTH=8, rst_n=0, all vk=1 -> o=0, sel=0, o_valid=0, r0..r3=0 with no clock edge needed.
- Single channel, with v2=1, i2=8'hA5, o_ready=1, others idle -> r2=1. Next edge: o=8'hA5, sel=2, o_valid=1. After v2 drops, o_valid=0 one cycle later.
- All channels valid, with i0=8'h11, i1=8'h22, i2=8'h33, i3=8'h44, o_ready=1 held -> consecutive cycles give sel=0,1,2,3,0,1 and o=11,22,33,44,11,22, with no idle cycles.
- Backpressure:
  - Hold o_ready=0 for 3 cycles while o_valid=1 and all vk=1 -> o and sel are stable and r0..r3=0.
  - Raise o_ready -> the next channel in rotation is loaded on the following edge.
- Mid-stream reset: pulse rst_n low between edges during all-valid streaming -> o_valid drops immediately. After release, the first grant is channel 0.
- MUX_CNT_EN, with CNT_W=8:
  - 5 transfers on channel 1 -> cnt1=5, and the other counters stay 0.
  - Preload channel 3 to 255 transfers, then 1 more -> cnt3=0.
